// File: rtl/inv_sub_add_round.sv
// Byte-serial AES-128 decryption round: InvShiftRows, InvSubBytes, AddRoundKey.
// Optional INV_SUB_ZEROIZE_EN clears state/key/result on the DONE->IDLE handoff.
module inv_sub_add_round (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic [127:0] i_Data,
    input  logic [127:0] i_Key,
    input  logic         i_Valid,
    output logic         o_InReady,
    output logic [127:0] o_Data,
    output logic         o_Valid,
    input  logic         i_Ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t       r_Fsm;
    state_t       w_FsmNext;
    logic [3:0]   r_Cnt;
    logic [127:0] r_State;
    logic [127:0] r_Key;
    logic [127:0] r_Result;

    logic [1:0]   w_Row;
    logic [1:0]   w_Col;
    logic [1:0]   w_SrcCol;
    logic [6:0]   w_SrcBit;
    logic [6:0]   w_DstBit;
    logic [7:0]   w_InByte;
    logic [7:0]   w_KeyByte;
    logic [7:0]   w_OutByte;
    logic         w_Accept;
    logic         w_Handoff;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    assign w_Row     = r_Cnt[1:0];
    assign w_Col     = r_Cnt[3:2];
    assign w_SrcCol  = w_Col - w_Row;
    assign w_SrcBit  = 7'd127 - {w_SrcCol, w_Row, 3'b000};
    assign w_DstBit  = 7'd127 - {r_Cnt, 3'b000};
    assign w_InByte  = r_State[w_SrcBit -: 8];
    assign w_KeyByte = r_Key[w_DstBit -: 8];
    assign w_OutByte = inv_sbox(w_InByte) ^ w_KeyByte;

    assign w_Accept  = (r_Fsm == S_IDLE) && i_Valid;
    assign w_Handoff = (r_Fsm == S_DONE) && i_Ready;

    always_comb begin
        w_FsmNext = r_Fsm;
        unique case (r_Fsm)
            S_IDLE:  if (i_Valid) w_FsmNext = S_SUB;
            S_SUB:   if (r_Cnt == 4'd15) w_FsmNext = S_DONE;
            S_DONE:  if (i_Ready) w_FsmNext = S_IDLE;
            default: w_FsmNext = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_Fsm <= S_IDLE;
        else       r_Fsm <= w_FsmNext;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Cnt    <= 4'd0;
            r_State  <= '0;
            r_Key    <= '0;
            r_Result <= '0;
        end else if (w_Accept) begin
            r_Cnt   <= 4'd0;
            r_State <= i_Data;
            r_Key   <= i_Key;
        end else if (r_Fsm == S_SUB) begin
            r_Result[w_DstBit -: 8] <= w_OutByte;
            r_Cnt <= (r_Cnt == 4'd15) ? 4'd0 : r_Cnt + 4'd1;
        end else if (w_Handoff) begin
`ifdef INV_SUB_ZEROIZE_EN
            r_State  <= '0;
            r_Key    <= '0;
            r_Result <= '0;
`else
            r_Result <= r_Result;
`endif
        end
    end

    assign o_InReady = (r_Fsm == S_IDLE);
    assign o_Valid   = (r_Fsm == S_DONE);
    assign o_Data    = r_Result;

endmodule

// File: tb/tb_inv_sub_add_round.sv
// Scoreboard bench for inv_sub_add_round: directed vectors, monitor pops on handshake.
module tb_inv_sub_add_round;

    logic         i_Clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic [127:0] i_Data = '0;
    logic [127:0] i_Key = '0;
    logic         i_Valid = 1'b0;
    logic         o_InReady;
    logic [127:0] o_Data;
    logic         o_Valid;
    logic         i_Ready = 1'b1;

    inv_sub_add_round dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Data    (i_Data),
        .i_Key     (i_Key),
        .i_Valid   (i_Valid),
        .o_InReady (o_InReady),
        .o_Data    (o_Data),
        .o_Valid   (o_Valid),
        .i_Ready   (i_Ready)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [127:0] d;
        int           c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge i_Clk) begin
        if (o_Valid && !prev_v) begin
            if (q.size() == 0) chk("unexpected_valid", 128'd1, 128'd0);
            else chk("latency", 128'(cyc - q[0].c), 128'd16);
        end
        if (o_Valid && i_Ready && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("data", o_Data, e.d);
        end
        prev_v = o_Valid;
    end

    task automatic send(input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] exp, input bit push);
        exp_t e;
        int n = 0;
        do begin
            @(negedge i_Clk);
            n++;
        end while (!o_InReady && n < 40);
        chk("inready_wait", 128'(o_InReady), 128'd1);
        i_Valid = 1'b1;
        i_Data  = d;
        i_Key   = k;
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        i_Data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        i_Key   = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
        chk("inready_low", 128'(o_InReady), 128'd0);
        if (push) begin
            e.d = exp;
            e.c = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge i_Clk);
            n++;
        end while (!o_Valid && n < 40);
        chk("valid_wait", 128'(o_Valid), 128'd1);
    endtask

    logic [127:0] v_Zero52;
    logic [127:0] v_Key;
    logic [127:0] v_Sr;
    logic [127:0] v_SrExp;
    logic [127:0] v_Idle;

    initial begin
        v_Zero52 = {16{8'h52}};
        v_Key    = 128'h000102030405060708090a0b0c0d0e0f;
        v_Sr     = {16{8'h63}};
        v_Sr[119:112] = 8'h7c;
        v_SrExp  = '0;
        v_SrExp[87:80] = 8'h01;
`ifdef INV_SUB_ZEROIZE_EN
        v_Idle = '0;
`else
        v_Idle = v_Key;
`endif

        repeat (3) @(posedge i_Clk);
        #1;
        chk("rst_valid", 128'(o_Valid), 128'd0);
        chk("rst_inready", 128'(o_InReady), 128'd1);
        chk("rst_data", o_Data, 128'd0);
        i_Rst = 1'b0;

        send('0, '0, v_Zero52, 1'b1);
        wait_valid();
        @(negedge i_Clk);
        chk("one_cycle_valid", 128'(o_Valid), 128'd0);
        chk("b2b_inready", 128'(o_InReady), 128'd1);

        send({16{8'h63}}, v_Key, v_Key, 1'b1);
        wait_valid();
        @(negedge i_Clk);
        chk("idle_data", o_Data, v_Idle);

        @(posedge i_Clk);
        #1;
        i_Ready = 1'b0;
        send(v_Sr, '0, v_SrExp, 1'b1);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 128'(o_Valid), 128'd1);
            chk("bp_data", o_Data, v_SrExp);
            chk("bp_inready", 128'(o_InReady), 128'd0);
            @(posedge i_Clk);
            #1;
            i_Valid = i[0];
            i_Data  = {16{8'h11}};
            @(negedge i_Clk);
        end
        @(posedge i_Clk);
        #1;
        i_Valid = 1'b0;
        i_Ready = 1'b1;
        @(posedge i_Clk);
        #1;
        chk("rel_inready", 128'(o_InReady), 128'd1);
        chk("rel_valid", 128'(o_Valid), 128'd0);

        send('0, '0, '0, 1'b0);
        repeat (7) @(posedge i_Clk);
        #1;
        i_Rst = 1'b1;
        #1;
        chk("abort_valid", 128'(o_Valid), 128'd0);
        chk("abort_inready", 128'(o_InReady), 128'd1);
        chk("abort_data", o_Data, 128'd0);
        @(negedge i_Clk);
        i_Rst = 1'b0;

        send('0, '0, v_Zero52, 1'b1);
        wait_valid();
        @(negedge i_Clk);
        chk("post_rst_drop", 128'(o_Valid), 128'd0);

        repeat (4) @(negedge i_Clk);
        chk("queue_empty", 128'(q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_sub_add_round.md
# inv_sub_add_round

Byte-serial AES-128 decryption round stage: applies InvShiftRows, then InvSubBytes, then AddRoundKey to one 128-bit state. It sits directly upstream of the combinational inverse MixColumns stage and feeds it one state per handshake. It uses a single shared inverse S-box over 16 cycles to trade throughput for area. The output word has the same column/byte packing that the inverse MixColumns stage consumes.

## Interface
- No parameters.
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Data  in  128  input state.
- i_Key  in  128  round key, sampled together with i_Data.
- i_Valid  in  1  input state/key valid.
- o_InReady  out  1  block can accept input; high only in IDLE.
- o_Data  out  128  result state; valid while o_Valid is high.
- o_Valid  out  1  result available.
- i_Ready  in  1  downstream accepts result.

## Operation
- Byte map: s[r][c] occupies bits [127-8*(4c+r) -: 8]. Column c is bits [127-32c -: 32]; row 0 is the MSB byte of each column.
- InvShiftRows: t[r][c] = s[r][(c-r) mod 4].
- Per byte: out[r][c] = InvSBox(t[r][c]) ^ k[r][c]. InvSBox is the FIPS-197 inverse S-box.
  - The inverse S-box may be a LUT, or an inverse affine transform followed by a GF(2^8) inverse (poly 0x11b, 0→0).
- FSM states:
  - IDLE: o_InReady=1. If i_Valid is high, latch i_Data into the state register and i_Key into the key register, set cnt=0, and go to SUB.
  - SUB: each cycle, process the byte at linear index p=cnt (r=p%4, c=p/4) and write it into the result register at p. Increment cnt. When cnt==15, go to DONE.
  - DONE: o_Valid=1 and o_Data = result register. If i_Ready is high, go to IDLE.
- i_Valid is ignored outside IDLE. Input is held only via the latched registers; upstream may change i_Data/i_Key after the accept edge.
- The result register holds its value in IDLE; o_Data is meaningful only while o_Valid is high.
- cnt is 4 bits and wraps only via the FSM exit; it never counts past 15.

## Timing
- Reset (asynchronous, immediate): FSM=IDLE, cnt=0, and state, key and result registers = 0. Outputs: o_Valid=0, o_InReady=1, o_Data=0.
- Accept edge A (IDLE, i_Valid=1): o_InReady falls after A.
- SUB occupies the 16 cycles after A. o_Valid rises after edge A+16.
- Back-to-back operation: a DONE cycle with i_Ready=1 returns to IDLE at the next edge. The earliest next accept is one cycle later. Throughput is 1 block per 18 cycles with i_Ready tied high.
- o_Valid/o_Data stay stable while i_Ready=0 (backpressure of arbitrary length).
- i_Ready while not in DONE has no effect.
- Reset asserted mid-SUB or in DONE aborts the operation: the partial result is discarded and o_Valid falls immediately. After reset release, the block is in IDLE and accepts on the first edge with i_Valid=1.
- Outputs are registered or FSM-decoded only; there is no combinational path from i_* to o_*.

## Configuration
- INV_SUB_ZEROIZE_EN defined: on the DONE→IDLE handoff edge, the state, key and result registers are cleared to 0, so o_Data reads 0 in IDLE. Secret material does not persist.
- Not defined: registers retain their last contents after handoff. o_Data holds the last result in IDLE.
- Timing and handshake are identical in both builds.

## Test plan
- Zero vector: i_Data=0, i_Key=0, i_Ready=1 → o_Valid rises 16 edges after accept, o_Data=0x5252…52 (16 bytes of 0x52), o_Valid high for 1 cycle.
- Key-only: i_Data=all 0x63, i_Key=0x000102030405060708090a0b0c0d0e0f → o_Data=0x000102030405060708090a0b0c0d0e0f.
- InvShiftRows: i_Data=all 0x63 except bits[119:112]=0x7c (s[1][0]), i_Key=0 → o_Data all 0x00 except bits[87:80]=0x01 (s[1][1]).
- Backpressure: hold i_Ready=0 for 20 cycles in DONE → o_Valid and o_Data stable and o_InReady=0 throughout. i_Valid pulses during this window are ignored. Release i_Ready → IDLE next edge.
- Reset mid-operation: assert i_Rst at cnt=7 → o_Valid=0 and o_InReady=1 immediately. Then run the zero-vector case → correct 0x52… result with nominal latency.
- Zeroize: complete the key-only case, then check IDLE o_Data. Expect 0 with INV_SUB_ZEROIZE_EN defined, and 0x000102…0f without it.
